simple_pipe_core: RTL and testbench
===================================

Name: simple_pipe_core

Overview:
- Pipelined implementation of the simplePipe 8-bit ISA.
- Instruction fields: opcode inst[7:6], rs1 inst[5:4], rs2 inst[3:2], rd inst[1:0].
- Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND.
- Implementation side of the per-instruction ILA refinement checks. It exposes its architectural registers and a commit strobe so the checker can align each retired instruction with the ILA model's single-step update.

Parameters:
- DW, 8, datapath width (inst stays 8 bits)
- R0_INIT, 8'h00, reset value of r0
- R1_INIT, 8'h00, reset value of r1
- R2_INIT, 8'h00, reset value of r2
- R3_INIT, 8'h00, reset value of r3

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- inst_valid  in  1  inst is sampled this cycle
- inst  in  8  instruction word
- r0  out  DW  architectural register 0
- r1  out  DW  architectural register 1
- r2  out  DW  architectural register 2
- r3  out  DW  architectural register 3
- commit_valid  out  1  a non-NOP instruction wrote back this cycle (registered)
- commit_rd  out  2  destination of the committed instruction
- commit_data  out  DW  value written
- retire_cnt  out  8  count of committed instructions, saturating

Behaviour:
- Reset (rst high at a posedge):
  - r0..r3 load R0_INIT..R3_INIT.
  - All stage valid bits clear.
  - commit_valid=0, commit_rd=0, commit_data=0, retire_cnt=0.
  - Reset mid-operation discards every in-flight instruction; none writes back.
- No stalls. One instruction is accepted per cycle when inst_valid=1; inst_valid=0 inserts a bubble.
- Stage ID: registers inst and valid at edge E0. The sampled NOP is carried as valid=0.
- Stage EX: at E1, latches op, rd and both operands.
  - Each operand resolves by priority:
    1. EX-stage result, if EX valid and EX rd==rs.
    2. WB-stage result, if WB valid and WB rd==rs.
    3. Register file.
- Stage WB: at E2, latches the result, computed as follows:
  - ADD: (a+b) mod 2^DW.
  - SUB: (a-b) mod 2^DW.
  - AND: a&b.
- Register-file write: at E3, r[rd] updates. The new value is visible on r* after E3, so latency is 3 edges from sampling.
- Commit outputs: commit_valid/commit_rd/commit_data pulse for exactly one cycle after E3.
- Only rd changes on a commit; the other three registers hold.
- Back-to-back dependents therefore see results identical to sequential ILA execution.
- rs1==rs2, and rd equal to a source, are both legal; forwarding applies to each operand independently.
- retire_cnt increments on each commit and saturates at 255.
- No combinational path from any input to any output.

Decomposition:
- Package simple_pipe_pkg holds:
  - opcode constants OP_NOP/OP_ADD/OP_SUB/OP_AND;
  - field position constants;
  - a stage record typedef (valid, op, rd, a, b / result).
- Sub-module simple_pipe_alu: combinational op x a x b -> result. It is shared conceptually with the ILA semantics.

Test Plan:
- INIT r0=0x0F, r1=0xF3, r2=0x05, r3=0x80; single 0xC6 (AND r2=r0&r1) then bubbles -> commit at 3rd cycle: rd=2, data=0x03; r2=0x03; other registers unchanged; retire_cnt=1.
- Same INIT; 0xC6 immediately followed by 0x5B (ADD r3=r1+r2, EX forwarding) -> r2=0x03 and r3=0xF6, on consecutive commit cycles.
- Same INIT; 0xC6, one bubble, then 0x5B (WB forwarding) -> r3=0xF6. With two bubbles -> r3=0xF6 read from the register file.
- Same INIT; 0x8C (SUB r0=r0-r3) -> r0=0x8F, wrap-around; then 0x00 (NOP) -> no commit_valid, registers unchanged.
- Same INIT; 0xC6, then rst asserted the next cycle -> r2 remains 0x05, no commit_valid, retire_cnt=0.
- Same INIT; 300 consecutive 0xC6 -> retire_cnt saturates at 255; each commit writes r2=0x03.

Source files
------------

// File: rtl/simple_pipe_pkg.sv
// simple_pipe_pkg: opcodes, instruction field positions and stage record shared by the simplePipe core
package simple_pipe_pkg;
    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2,
        OP_AND = 2'd3
    } op_e;
    localparam int OP_HI  = 7;
    localparam int OP_LO  = 6;
    localparam int RS1_HI = 5;
    localparam int RS1_LO = 4;
    localparam int RS2_HI = 3;
    localparam int RS2_LO = 2;
    localparam int RD_HI  = 1;
    localparam int RD_LO  = 0;
    // Width-independent part of a stage record; data fields are added where DW is known.
    typedef struct packed {
        logic       valid;
        op_e        op;
        logic [1:0] rd;
    } stage_t;
endpackage

// File: rtl/simple_pipe_alu.sv
// simple_pipe_alu: combinational op x a x b -> result, matching the ILA single-step semantics
module simple_pipe_alu
    import simple_pipe_pkg::*;
#(
    parameter int DW = 8
) (
    input  op_e           op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] y
);
    always_comb begin
        y = op == OP_ADD ? a + b :
            op == OP_SUB ? a - b :
            op == OP_AND ? a & b : '0;
    end
endmodule

// File: rtl/simple_pipe_core.sv
// simple_pipe_core: ID/EX/WB/RF-write pipeline for the simplePipe ISA with full forwarding and a commit trace
module simple_pipe_core
    import simple_pipe_pkg::*;
#(
    parameter int            DW      = 8,
    parameter logic [DW-1:0] R0_INIT = '0,
    parameter logic [DW-1:0] R1_INIT = '0,
    parameter logic [DW-1:0] R2_INIT = '0,
    parameter logic [DW-1:0] R3_INIT = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inst_valid,
    input  logic [7:0]    inst,
    output logic [DW-1:0] r0,
    output logic [DW-1:0] r1,
    output logic [DW-1:0] r2,
    output logic [DW-1:0] r3,
    output logic          commit_valid,
    output logic [1:0]    commit_rd,
    output logic [DW-1:0] commit_data,
    output logic [7:0]    retire_cnt
);
    typedef struct packed {
        stage_t        ctl;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } ex_t;
    typedef struct packed {
        logic          valid;
        logic [1:0]    rd;
        logic [DW-1:0] res;
    } wb_t;

    localparam logic [DW-1:0] RF_INIT [4] = '{R0_INIT, R1_INIT, R2_INIT, R3_INIT};

    logic          id_valid_q, id_valid_d;
    logic [7:0]    id_inst_q, id_inst_d;
    ex_t           ex_q, ex_d;
    wb_t           wb_q, wb_d;
    logic [DW-1:0] ex_res;
    logic [DW-1:0] rf_q [4];
    logic [DW-1:0] rf_d [4];
    logic          commit_valid_q, commit_valid_d;
    logic [1:0]    commit_rd_q, commit_rd_d;
    logic [DW-1:0] commit_data_q, commit_data_d;
    logic [7:0]    retire_cnt_q, retire_cnt_d;

    simple_pipe_alu #(.DW(DW)) u_alu (
        .op(ex_q.ctl.op),
        .a (ex_q.a),
        .b (ex_q.b),
        .y (ex_res)
    );

    // Youngest producer wins: EX result, then WB result, then the register file.
    function automatic logic [DW-1:0] fwd(input logic [1:0] rs);
        return (ex_q.ctl.valid && ex_q.ctl.rd == rs) ? ex_res :
               (wb_q.valid && wb_q.rd == rs) ? wb_q.res : rf_q[rs];
    endfunction

    always_comb begin
        id_valid_d = inst_valid && inst[OP_HI:OP_LO] != OP_NOP;
        id_inst_d = inst;
        ex_d.ctl.valid = id_valid_q;
        ex_d.ctl.op = op_e'(id_inst_q[OP_HI:OP_LO]);
        ex_d.ctl.rd = id_inst_q[RD_HI:RD_LO];
        ex_d.a = fwd(id_inst_q[RS1_HI:RS1_LO]);
        ex_d.b = fwd(id_inst_q[RS2_HI:RS2_LO]);
        wb_d.valid = ex_q.ctl.valid;
        wb_d.rd = ex_q.ctl.rd;
        wb_d.res = ex_res;
        rf_d = rf_q;
        if (wb_q.valid) rf_d[wb_q.rd] = wb_q.res;
        commit_valid_d = wb_q.valid;
        commit_rd_d = wb_q.valid ? wb_q.rd : commit_rd_q;
        commit_data_d = wb_q.valid ? wb_q.res : commit_data_q;
        retire_cnt_d = (wb_q.valid && retire_cnt_q != 8'hFF) ? retire_cnt_q + 8'd1 : retire_cnt_q;
    end

    always_ff @(posedge clk) begin
        id_valid_q <= rst ? 1'b0 : id_valid_d;
        id_inst_q <= id_inst_d;
        ex_q <= rst ? '0 : ex_d;
        wb_q <= rst ? '0 : wb_d;
        for (int i = 0; i < 4; i++) rf_q[i] <= rst ? RF_INIT[i] : rf_d[i];
        commit_valid_q <= rst ? 1'b0 : commit_valid_d;
        commit_rd_q <= rst ? 2'd0 : commit_rd_d;
        commit_data_q <= rst ? '0 : commit_data_d;
        retire_cnt_q <= rst ? 8'd0 : retire_cnt_d;
    end

    assign r0 = rf_q[0];
    assign r1 = rf_q[1];
    assign r2 = rf_q[2];
    assign r3 = rf_q[3];
    assign commit_valid = commit_valid_q;
    assign commit_rd = commit_rd_q;
    assign commit_data = commit_data_q;
    assign retire_cnt = retire_cnt_q;
endmodule

// File: tb/tb_simple_pipe_core.sv
// tb_simple_pipe_core: directed scoreboard bench comparing commits and registers against a sequential ISA model
module tb_simple_pipe_core;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       inst_valid = 1'b0;
    logic [7:0] inst = 8'h00;
    logic [7:0] r0, r1, r2, r3, commit_data, retire_cnt;
    logic       commit_valid;
    logic [1:0] commit_rd;

    typedef struct {
        int         due;
        logic [1:0] rd;
        logic [7:0] data;
    } exp_t;

    exp_t       q[$];
    logic [7:0] init_v [4];
    logic [7:0] mreg [4];
    logic [7:0] arch [4];
    int         acnt = 0;
    int         cyc = 0;
    int         n = 0;
    int         errs = 0;

    always #5 clk = ~clk;

    simple_pipe_core #(
        .DW(8), .R0_INIT(8'h0F), .R1_INIT(8'hF3), .R2_INIT(8'h05), .R3_INIT(8'h80)
    ) dut (
        .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst(inst),
        .r0(r0), .r1(r1), .r2(r2), .r3(r3),
        .commit_valid(commit_valid), .commit_rd(commit_rd),
        .commit_data(commit_data), .retire_cnt(retire_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_outputs();
        logic ev;
        exp_t e;
        ev = q.size() != 0 && q[0].due == cyc;
        chk("commit_valid", commit_valid, ev);
        if (ev) begin
            e = q.pop_front();
            chk("commit_rd", commit_rd, e.rd);
            chk("commit_data", commit_data, e.data);
            arch[e.rd] = e.data;
            if (acnt < 255) acnt++;
        end
        chk("r0", r0, arch[0]);
        chk("r1", r1, arch[1]);
        chk("r2", r2, arch[2]);
        chk("r3", r3, arch[3]);
        chk("retire_cnt", retire_cnt, acnt);
    endtask

    task automatic step(input logic v, input logic [7:0] i);
        logic [7:0] a, b, y;
        inst_valid = v;
        inst = i;
        @(posedge clk);
        cyc++;
        if (v && i[7:6] != 2'd0) begin
            a = mreg[i[5:4]];
            b = mreg[i[3:2]];
            y = i[7:6] == 2'd1 ? a + b : i[7:6] == 2'd2 ? a - b : a & b;
            mreg[i[1:0]] = y;
            q.push_back('{cyc + 3, i[1:0], y});
        end
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        inst_valid = 1'b0;
        @(posedge clk);
        cyc++;
        #1;
        q.delete();
        for (int k = 0; k < 4; k++) begin
            mreg[k] = init_v[k];
            arch[k] = init_v[k];
        end
        acnt = 0;
        check_outputs();
        chk("rst_commit_rd", commit_rd, 2'd0);
        chk("rst_commit_data", commit_data, 8'h00);
        rst = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 8 && q.size() != 0; k++) step(1'b0, 8'h00);
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        init_v[0] = 8'h0F;
        init_v[1] = 8'hF3;
        init_v[2] = 8'h05;
        init_v[3] = 8'h80;
        do_reset();
        step(1'b1, 8'hC6);
        drain();
        chk("and_r2", r2, 8'h03);
        chk("and_cnt", retire_cnt, 8'd1);
        do_reset();
        step(1'b1, 8'hC6);
        step(1'b1, 8'h5B);
        drain();
        chk("exfwd_r3", r3, 8'hF6);
        do_reset();
        step(1'b1, 8'hC6);
        step(1'b0, 8'h00);
        step(1'b1, 8'h5B);
        drain();
        chk("wbfwd_r3", r3, 8'hF6);
        do_reset();
        step(1'b1, 8'hC6);
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        step(1'b1, 8'h5B);
        drain();
        chk("rf_r3", r3, 8'hF6);
        do_reset();
        step(1'b1, 8'h8C);
        step(1'b1, 8'h00);
        drain();
        step(1'b0, 8'h00);
        chk("sub_r0", r0, 8'h8F);
        chk("nop_cnt", retire_cnt, 8'd1);
        do_reset();
        step(1'b1, 8'hC6);
        do_reset();
        for (int k = 0; k < 5; k++) step(1'b0, 8'h00);
        chk("flush_r2", r2, 8'h05);
        chk("flush_cnt", retire_cnt, 8'd0);
        do_reset();
        for (int k = 0; k < 300; k++) step(1'b1, 8'hC6);
        drain();
        chk("sat_cnt", retire_cnt, 8'd255);
        chk("sat_r2", r2, 8'h03);
        $display("== %0d vectors applied, %0d miscompares ==", n, errs);
        $finish;
    end
endmodule
